// File: rtl/controller_dd_vote.sv
`default_nettype none
// ============================================================================
//  Module      : controller_dd_vote
//  Description : Differential-delay PUF evaluation controller. Runs the DD
//                array a latched number of times, each for a latched number
//                of cycles with a relax gap in between. Per-bit ones counts
//                are reduced to a majority-voted response and an
//                instability mask. The last raw sample is also kept.
//  Revision    : 1.0 - initial release
// ============================================================================
module controller_dd_vote #(
   parameter int PUF_WIDTH    = 128,
   parameter int CNT_WIDTH    = 16,
   parameter int REP_WIDTH    = 4,
   parameter int CODE_WIDTH   = 8,
   parameter int TRIG_CODE    = 1,
   parameter int ABORT_CODE   = 2,
   parameter int RELAX_CYCLES = 4
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [CODE_WIDTH-1:0] CODE,
   input  logic [CNT_WIDTH-1:0]  CNT_VAL,
   input  logic [REP_WIDTH-1:0]  REP_VAL,
   input  logic [PUF_WIDTH-1:0]  PUF_OUT,
   output logic                  RESET_DD,
   output logic                  START_DD,
   output logic                  BUSY,
   output logic                  DONE,
   output logic [PUF_WIDTH-1:0]  PUF_OUT_REG,
   output logic [PUF_WIDTH-1:0]  UNSTABLE_MASK,
   output logic [PUF_WIDTH-1:0]  LAST_SAMPLE
);

   // Relax gap is clamped to at least one cycle
   localparam int                  c_RELAX_EFF = (RELAX_CYCLES < 1) ? 1 : RELAX_CYCLES;
   localparam int                  c_RLX_W     = $clog2(c_RELAX_EFF + 1);
   localparam logic [c_RLX_W-1:0]  c_RLX_LAST  = c_RLX_W'(c_RELAX_EFF);
   localparam logic [c_RLX_W-1:0]  c_RLX_ONE   = c_RLX_W'(1);
   localparam logic [CNT_WIDTH-1:0] c_CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [REP_WIDTH-1:0] c_REP_ONE  = REP_WIDTH'(1);
   localparam logic [CODE_WIDTH-1:0] c_TRIG    = CODE_WIDTH'(TRIG_CODE);
   localparam logic [CODE_WIDTH-1:0] c_ABORT   = CODE_WIDTH'(ABORT_CODE);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RUN    = 3'd1,
      S_SAMPLE = 3'd2,
      S_RELAX  = 3'd3,
      S_RESULT = 3'd4,
      S_WAIT   = 3'd5
   } state_t;

   state_t                               r_state;
   logic [CNT_WIDTH-1:0]                 r_len;
   logic [REP_WIDTH-1:0]                 r_reps;
   logic [CNT_WIDTH-1:0]                 r_cyc;
   logic [c_RLX_W-1:0]                   r_rlx;
   logic [REP_WIDTH-1:0]                 r_run;
   logic [PUF_WIDTH-1:0][REP_WIDTH-1:0]  r_ones;

   logic [PUF_WIDTH-1:0][REP_WIDTH-1:0]  w_ones_next;
   logic [PUF_WIDTH-1:0]                 w_maj;
   logic [PUF_WIDTH-1:0]                 w_unst;
   logic [REP_WIDTH-1:0]                 w_run_next;
   logic                                 w_trig;
   logic                                 w_abort;

   assign w_trig     = (CODE == c_TRIG);
   assign w_abort    = (CODE == c_ABORT);
   assign w_run_next = r_run + c_REP_ONE;

   // Per-bit vote evaluated on the counts as they will be after the current
   // sample, so the result can be registered on the same edge as the last
   // sample is accumulated. Ties (2*ones == N) resolve to 0.
   for (genvar gi = 0; gi < PUF_WIDTH; gi++) begin : g_bit
      assign w_ones_next[gi] = r_ones[gi] + REP_WIDTH'(PUF_OUT[gi]);
      assign w_maj[gi]       = {w_ones_next[gi], 1'b0} > {1'b0, r_reps};
      assign w_unst[gi]      = (w_ones_next[gi] != '0) && (w_ones_next[gi] != r_reps);
   end

   // Evaluation sequencer with registered outputs set alongside each state entry
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state       <= S_IDLE;
         r_len         <= '0;
         r_reps        <= '0;
         r_cyc         <= '0;
         r_rlx         <= '0;
         r_run         <= '0;
         r_ones        <= '0;
         RESET_DD      <= 1'b1;
         START_DD      <= 1'b0;
         BUSY          <= 1'b0;
         DONE          <= 1'b0;
         PUF_OUT_REG   <= '0;
         UNSTABLE_MASK <= '0;
         LAST_SAMPLE   <= '0;
      end else begin
         DONE <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_trig) begin
                  r_len    <= (CNT_VAL == '0) ? c_CNT_ONE : CNT_VAL;
                  r_reps   <= (REP_VAL == '0) ? c_REP_ONE : REP_VAL;
                  r_ones   <= '0;
                  r_run    <= '0;
                  r_cyc    <= c_CNT_ONE;
                  r_state  <= S_RUN;
                  RESET_DD <= 1'b0;
                  START_DD <= 1'b1;
                  BUSY     <= 1'b1;
               end
            end

            S_RUN: begin
               if (w_abort) begin
                  r_state  <= S_IDLE;
                  RESET_DD <= 1'b1;
                  START_DD <= 1'b0;
                  BUSY     <= 1'b0;
               end else if (r_cyc == r_len) begin
                  r_state  <= S_SAMPLE;
               end else begin
                  r_cyc    <= r_cyc + c_CNT_ONE;
               end
            end

            S_SAMPLE: begin
               if (w_abort) begin
                  // An aborted sample is discarded entirely
                  r_state  <= S_IDLE;
                  RESET_DD <= 1'b1;
                  START_DD <= 1'b0;
                  BUSY     <= 1'b0;
               end else begin
                  r_ones      <= w_ones_next;
                  r_run       <= w_run_next;
                  LAST_SAMPLE <= PUF_OUT;
                  RESET_DD    <= 1'b1;
                  START_DD    <= 1'b0;
                  if (w_run_next == r_reps) begin
                     r_state       <= S_RESULT;
                     DONE          <= 1'b1;
                     PUF_OUT_REG   <= w_maj;
                     UNSTABLE_MASK <= w_unst;
                  end else begin
                     r_state <= S_RELAX;
                     r_rlx   <= c_RLX_ONE;
                  end
               end
            end

            S_RELAX: begin
               if (w_abort) begin
                  r_state  <= S_IDLE;
                  RESET_DD <= 1'b1;
                  START_DD <= 1'b0;
                  BUSY     <= 1'b0;
               end else if (r_rlx == c_RLX_LAST) begin
                  r_state  <= S_RUN;
                  r_cyc    <= c_CNT_ONE;
                  RESET_DD <= 1'b0;
                  START_DD <= 1'b1;
               end else begin
                  r_rlx    <= r_rlx + c_RLX_ONE;
               end
            end

            S_RESULT: begin
               r_state <= S_WAIT;
               BUSY    <= 1'b0;
            end

            S_WAIT: begin
               // A held trigger must be released before another evaluation
               if (!w_trig) begin
                  r_state <= S_IDLE;
               end
            end

            default: begin
               r_state  <= S_IDLE;
               RESET_DD <= 1'b1;
               START_DD <= 1'b0;
               BUSY     <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/controller_dd_vote.md
# controller_dd_vote

Parametrised differential-delay PUF evaluation controller with repeated-evaluation majority voting. On a trigger code from the SPI command decoder it runs the DD PUF `REP_VAL` times, each for a programmable number of cycles, with a relax gap between runs. It accumulates per-bit ones counts and presents a majority-voted response, an instability mask and the last raw sample to the SPI readback registers.

## Interface
- `PUF_WIDTH`, 128: PUF response width.
- `CNT_WIDTH`, 16: run-length counter width.
- `REP_WIDTH`, 4: repetition count width (max 2^REP_WIDTH-1 runs).
- `CODE_WIDTH`, 8: command code width.
- `TRIG_CODE`, 1: code that starts an evaluation.
- `ABORT_CODE`, 2: code that aborts an evaluation in progress.
- `RELAX_CYCLES`, 4: DD reset gap between runs (values <1 behave as 1).

Ports:
- `CLK` in 1: single clock, all logic on rising edge.
- `RESET` in 1: asynchronous, active-low reset.
- `CODE` in CODE_WIDTH: command code from SPI decoder, level-sensitive.
- `CNT_VAL` in CNT_WIDTH: run length in cycles, latched at trigger.
- `REP_VAL` in REP_WIDTH: number of runs N, latched at trigger.
- `PUF_OUT` in PUF_WIDTH: raw DD PUF response.
- `RESET_DD` out 1: DD array reset, high = held in reset.
- `START_DD` out 1: DD array launch.
- `BUSY` out 1: high from first RUN cycle until leaving RESULT or abort.
- `DONE` out 1: one-cycle pulse, results valid.
- `PUF_OUT_REG` out PUF_WIDTH: majority-voted response.
- `UNSTABLE_MASK` out PUF_WIDTH: bit i high if runs disagreed on bit i.
- `LAST_SAMPLE` out PUF_WIDTH: raw response of the most recent run.

## Operation
- All outputs are registered; they take their per-state values in the same cycle the state is entered.
- Effective run length L = max(CNT_VAL,1). Effective repetitions N = max(REP_VAL,1). Both are latched on the trigger edge; later changes are ignored.
- States:
  - IDLE: RESET_DD=1, START_DD=0. If CODE==TRIG_CODE, latch L and N, clear the per-bit ones counters and the run counter, then go to RUN.
  - RUN: RESET_DD=0, START_DD=1. The cycle counter counts from 1. After L RUN cycles, go to SAMPLE.
  - SAMPLE: RESET_DD=0, START_DD=1, one cycle. On the exit edge: ones[i] += PUF_OUT[i], LAST_SAMPLE <= PUF_OUT, and the run counter increments. If run == N, go to RESULT; otherwise go to RELAX.
  - RELAX: RESET_DD=1, START_DD=0 for RELAX_CYCLES cycles, then RUN.
  - RESULT: one cycle. DONE=1. PUF_OUT_REG[i] = (2·ones[i] > N); ties resolve to 0. UNSTABLE_MASK[i] = (ones[i]≠0 && ones[i]≠N). Then go to WAIT.
  - WAIT: RESET_DD=1, START_DD=0. Stay until CODE≠TRIG_CODE, then go to IDLE. A held trigger never re-arms.
- Abort: CODE==ABORT_CODE in RUN, SAMPLE or RELAX sends the block to IDLE on the next edge.
  - RESET_DD=1, START_DD=0, BUSY=0.
  - No DONE pulse.
  - PUF_OUT_REG, UNSTABLE_MASK and LAST_SAMPLE are unchanged, except that the SAMPLE exit edge of an aborted SAMPLE cycle does not update LAST_SAMPLE.
  - Abort takes priority over every other transition.
- Arithmetic: ones counters and run counter are REP_WIDTH bits, so no overflow is possible since N ≤ 2^REP_WIDTH-1. The majority compare is done at REP_WIDTH+1 bits.
- Results hold until the next DONE. An unrecognised CODE has no effect.

## Timing
- Reset values, asserted asynchronously while RESET=0: state IDLE, RESET_DD=1, START_DD=0, BUSY=0, DONE=0, PUF_OUT_REG=0, UNSTABLE_MASK=0, LAST_SAMPLE=0, all counters 0.
- Reset release: the first active edge can accept a trigger.
- Trigger: sampled on edge k with CODE==TRIG_CODE in IDLE.
  - START_DD=1 and BUSY=1 from cycle k+1.
- Per run: START_DD high for L+1 consecutive cycles (L RUN + 1 SAMPLE), then low for RELAX_CYCLES cycles between runs.
- DONE is high in cycle k+1+N·(L+1)+(N-1)·RELAX_CYCLES, for exactly one cycle. PUF_OUT_REG and UNSTABLE_MASK are valid in that same cycle. BUSY falls in the next cycle.
- PUF_OUT must be stable at the SAMPLE-exit edge. The upstream synchroniser is the integrator's responsibility.
- Reset mid-run: everything returns to reset values immediately. No DONE pulse.

## Test plan
- N=1, CNT_VAL=3, PUF_OUT=0xA5…A5 → START_DD high 4 cycles, DONE at k+5, PUF_OUT_REG=0xA5…A5, UNSTABLE_MASK=0.
- N=3, RELAX_CYCLES=4, CNT_VAL=2, runs return 0xF0, 0xFF, 0x0F in the low byte → DONE at k+18, PUF_OUT_REG low byte=0xFF, UNSTABLE_MASK low byte=0xFF, LAST_SAMPLE=0x0F.
- N=4, runs 1,1,0,0 on bit0 → PUF_OUT_REG[0]=0 (tie), UNSTABLE_MASK[0]=1.
- CNT_VAL=0 and REP_VAL=0 → behaves as L=1, N=1: START_DD high 2 cycles, DONE at k+3.
- ABORT_CODE during the second RELAX → IDLE next edge, no DONE, outputs keep prior results. Trigger held through WAIT → no second run until CODE drops.
- RESET low during RUN → RESET_DD=1, START_DD=0, BUSY=0, all result registers 0 asynchronously. A fresh trigger after release completes normally.
